// File: rtl/led_pattern_engine.sv
// N-LED pattern engine: input synchronisers, prescaler, speed subdivider,
// mode sequencer and pattern registers for eight display modes.
module led_pattern_engine #(
    parameter int          N_LEDS   = 8,
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic              clki,
    input  logic              reset,
    input  logic [2:0]        sw_mode,
    input  logic [1:0]        sw_speed,
    input  logic              sw_pause,
    input  logic              btn_step,
    output logic [N_LEDS-1:0] leds,
    output logic [2:0]        mode_act,
    output logic              adv
);

    localparam logic [31:0]       TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [N_LEDS-1:0] ONE       = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] MSB       = ONE << (N_LEDS - 1);
    localparam logic [N_LEDS-1:0] ALT       = N_LEDS'({16{2'b01}});

    typedef enum logic [2:0] {
        M_SHL   = 3'd0,
        M_SHR   = 3'd1,
        M_BNC   = 3'd2,
        M_BAR   = 3'd3,
        M_BLINK = 3'd4,
        M_ALT   = 3'd5,
        M_CNT   = 3'd6,
        M_JOHN  = 3'd7
    } mode_t;

    logic [6:0]        sync1;
    logic [6:0]        sync2;
    logic              step_d;
    logic [31:0]       presc;
    logic [2:0]        sub;
    logic              dir_left;

    logic [2:0]        mode_s;
    logic [1:0]        speed_s;
    logic              pause_s;
    logic              step_s;
    logic              step_rise;
    logic              base_tick;
    logic [2:0]        sub_lim;
    logic              en;
    logic              advance;
    logic              mode_chg;
    logic [N_LEDS-1:0] init_pat;
    logic [N_LEDS-1:0] nxt_pat;
    logic              nxt_dir;

    assign mode_s    = sync2[6:4];
    assign speed_s   = sync2[3:2];
    assign pause_s   = sync2[1];
    assign step_s    = sync2[0];
    assign step_rise = step_s & ~step_d;
    assign base_tick = (presc == TICK_LAST);
    assign sub_lim   = 3'((4'd1 << speed_s) - 4'd1);
    assign en        = base_tick && (sub == sub_lim);
    assign advance   = pause_s ? step_rise : en;
    assign mode_chg  = (mode_s != mode_act);

    always_comb begin
        init_pat = '0;
        case (mode_t'(mode_s))
            M_SHL:   init_pat = ONE;
            M_SHR:   init_pat = MSB;
            M_BNC:   init_pat = ONE;
            M_ALT:   init_pat = ALT;
            default: init_pat = '0;
        endcase
    end

    // Bounce reverses and moves on the same edge, so end LEDs show for one step.
    always_comb begin
        nxt_pat = leds;
        nxt_dir = dir_left;
        case (mode_t'(mode_act))
            M_SHL: nxt_pat = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
            M_SHR: nxt_pat = {leds[0], leds[N_LEDS-1:1]};
            M_BNC: begin
                if (dir_left) begin
                    if (leds[N_LEDS-1]) begin
                        nxt_pat = leds >> 1;
                        nxt_dir = 1'b0;
                    end else begin
                        nxt_pat = leds << 1;
                    end
                end else begin
                    if (leds[0]) begin
                        nxt_pat = leds << 1;
                        nxt_dir = 1'b1;
                    end else begin
                        nxt_pat = leds >> 1;
                    end
                end
            end
            M_BAR:   nxt_pat = (&leds) ? '0 : {leds[N_LEDS-2:0], 1'b1};
            M_BLINK: nxt_pat = ~leds;
            M_ALT:   nxt_pat = ~leds;
            M_CNT:   nxt_pat = leds + ONE;
            M_JOHN:  nxt_pat = {leds[N_LEDS-2:0], ~leds[N_LEDS-1]};
            default: nxt_pat = leds;
        endcase
    end

    always_ff @(posedge clki) begin
        if (!reset) begin
            sync1    <= '0;
            sync2    <= '0;
            step_d   <= 1'b0;
            presc    <= '0;
            sub      <= '0;
            dir_left <= 1'b1;
            leds     <= ONE;
            mode_act <= 3'd0;
            adv      <= 1'b0;
        end else begin
            sync1  <= {sw_mode, sw_speed, sw_pause, btn_step};
            sync2  <= sync1;
            step_d <= step_s;
            adv    <= 1'b0;
            if (mode_chg) begin
                mode_act <= mode_s;
                leds     <= init_pat;
                dir_left <= 1'b1;
                presc    <= '0;
                sub      <= '0;
            end else begin
                if (!pause_s) begin
                    presc <= base_tick ? '0 : presc + 32'd1;
                    // >= also clears a sub left above a freshly lowered limit
                    if (base_tick)
                        sub <= (sub >= sub_lim) ? 3'd0 : sub + 3'd1;
                end
                if (advance) begin
                    leds     <= nxt_pat;
                    dir_left <= nxt_dir;
                    adv      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed and randomised bench for led_pattern_engine with a
// step-index reference model of every display mode.
module tb_led_pattern_engine;

    localparam int N  = 8;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   sw_mode;
    logic [1:0]   sw_speed;
    logic         sw_pause;
    logic         btn_step;
    logic [N-1:0] leds;
    logic [2:0]   mode_act;
    logic         adv;

    int passed = 0;
    int total  = 0;

    logic [6:0]  h1, h2, h3;
    int          mact, phase, sub;
    int unsigned k;
    logic        madv;

    led_pattern_engine #(.N_LEDS(N), .TICK_DIV(TD)) dut (
        .clki     (clk),
        .reset    (reset),
        .sw_mode  (sw_mode),
        .sw_speed (sw_speed),
        .sw_pause (sw_pause),
        .btn_step (btn_step),
        .leds     (leds),
        .mode_act (mode_act),
        .adv      (adv)
    );

    always #5 clk = ~clk;

    // Pattern shown after k advances since the mode was loaded.
    function automatic logic [N-1:0] pat(input int m, input int unsigned kk);
        int unsigned p;
        int unsigned all;
        all = (1 << N) - 1;
        case (m)
            0: pat = N'(1 << (kk % N));
            1: pat = N'(1 << (N - 1 - kk % N));
            2: begin
                p = kk % (2 * N - 2);
                pat = (p < N) ? N'(1 << p) : N'(1 << (2 * N - 2 - p));
            end
            3: pat = N'((1 << (kk % (N + 1))) - 1);
            4: pat = kk[0] ? N'(all) : N'(0);
            5: pat = kk[0] ? N'(32'hAA) : N'(32'h55);
            6: pat = N'(kk % (1 << N));
            default: begin
                p = kk % (2 * N);
                if (p <= N) pat = N'((1 << p) - 1);
                else        pat = N'(all & ~((1 << (p - N)) - 1));
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        logic [6:0] in;
        int lim;
        logic base, en, rise, a;
        @(posedge clk);
        in = {sw_mode, sw_speed, sw_pause, btn_step};
        if (!reset) begin
            mact = 0; k = 0; phase = 0; sub = 0; madv = 1'b0;
            h1 = '0; h2 = '0; h3 = '0;
        end else begin
            madv = 1'b0;
            if (int'(h2[6:4]) != mact) begin
                mact = int'(h2[6:4]); k = 0; phase = 0; sub = 0;
            end else begin
                lim  = (1 << h2[3:2]) - 1;
                base = (phase == TD - 1);
                en   = base && (sub == lim);
                rise = h2[0] && !h3[0];
                if (!h2[1]) begin
                    phase = (phase + 1) % TD;
                    if (base) sub = (sub >= lim) ? 0 : sub + 1;
                end
                a = h2[1] ? rise : en;
                if (a) begin
                    k++;
                    madv = 1'b1;
                end
            end
            h3 = h2; h2 = h1; h1 = in;
        end
        #1;
        check("leds", 32'(leds), 32'(pat(mact, k)));
        check("mode_act", 32'(mode_act), 32'(mact));
        check("adv", 32'(adv), 32'(madv));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic step_pulse();
        btn_step = 1'b1;
        ticks(3);
        btn_step = 1'b0;
        ticks(3);
    endtask

    initial begin
        int guard;
        reset = 1'b0; sw_mode = 3'd0; sw_speed = 2'd0;
        sw_pause = 1'b0; btn_step = 1'b0;

        // 1: reset then shift-left
        ticks(2);
        check("rst_leds", 32'(leds), 32'h01);
        check("rst_adv", 32'(adv), 32'h0);
        reset = 1'b1;
        ticks(40);

        // 2: bounce, 16+ steps
        sw_mode = 3'd2;
        ticks(16 * TD + 12);

        // 3: binary counter at speed 2, then 256 forced steps
        sw_mode = 3'd6; sw_speed = 2'd2;
        ticks(50);
        sw_pause = 1'b1;
        ticks(4);
        for (int i = 0; i < 256; i++) step_pulse();
        sw_pause = 1'b0;
        ticks(20);

        // 4: bar fill with pause and steps
        sw_mode = 3'd3; sw_speed = 2'd0;
        ticks(30);
        sw_pause = 1'b1;
        ticks(100);
        for (int i = 0; i < 3; i++) step_pulse();
        sw_pause = 1'b0;
        ticks(20);

        // 5: 0 -> 7 with the load landing on an en edge
        sw_mode = 3'd0;
        ticks(30);
        guard = 0;
        while (phase != 1 && guard < 20) begin
            tick();
            guard++;
        end
        check("phase_align", 32'(phase), 32'd1);
        sw_mode = 3'd7;
        ticks(3);
        check("m7_mode", 32'(mode_act), 32'd7);
        check("m7_leds", 32'(leds), 32'h00);
        check("m7_adv", 32'(adv), 32'h0);
        ticks(17 * TD);

        // 6: reset while paused in mode 5
        sw_mode = 3'd5;
        ticks(10);
        sw_pause = 1'b1;
        ticks(6);
        reset = 1'b0;
        tick();
        check("mid_rst_leds", 32'(leds), 32'h01);
        check("mid_rst_mode", 32'(mode_act), 32'd0);
        check("mid_rst_adv", 32'(adv), 32'h0);
        reset = 1'b1;
        ticks(10);
        sw_pause = 1'b0;
        ticks(10);

        // random switch activity
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) sw_mode = 3'($urandom_range(7));
            if ($urandom_range(29) == 0) sw_speed = 2'($urandom_range(3));
            if ($urandom_range(59) == 0) sw_pause = ~sw_pause;
            if ($urandom_range(3) == 0) btn_step = ~btn_step;
            reset = ($urandom_range(299) != 0);
            tick();
        end
        reset = 1'b1;
        ticks(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
